// File: rtl/share_register_pipeline.sv
// Elastic register pipeline carrying SHARES independent shares of WIDTH bits
// through DEPTH stages, with bubble collapsing, synchronous flush, occupancy
// tracking and optional zeroing of idle stage registers.
module share_register_pipeline #(
  parameter int unsigned SHARES        = 3,
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned DEPTH         = 3,
  parameter bit          CLEAR_ON_IDLE = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SHARES*WIDTH-1:0]          in_shares,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SHARES*WIDTH-1:0]          out_shares,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

  localparam int unsigned DW = SHARES * WIDTH;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]          v_q, v_d;
  logic [DEPTH-1:0]          adv;
  logic [DEPTH-1:0][DW-1:0]  d_q, d_d;
  logic [OW-1:0]             occ_q, occ_d;
  logic                      in_fire;
  logic                      out_fire;

  // Advance chain: a valid stage moves when any stage below it is empty or
  // the consumer drains the last stage (room propagates upstream).
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      adv[k] = v_q[k] & room;
      room   = room | ~v_q[k];
    end
  end

  // Handshakes; input is refused while flushing.
  always_comb begin
    in_ready = ~flush & (~v_q[0] | adv[0]);
    in_fire  = in_valid & in_ready;
    out_fire = adv[DEPTH-1];
  end

  // Next-state for stage valids, data and occupancy.
  always_comb begin
    v_d   = v_q;
    d_d   = d_q;
    occ_d = occ_q;

    if (in_fire) begin
      v_d[0] = 1'b1;
      d_d[0] = in_shares;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end

    for (int k = 1; k < int'(DEPTH); k++) begin
      if (adv[k-1]) begin
        v_d[k] = 1'b1;
        d_d[k] = d_q[k-1];
      end else if (adv[k]) begin
        v_d[k] = 1'b0;
      end
    end

    // Empty stages hold zero so stale shares never linger or toggle through.
    if (CLEAR_ON_IDLE) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (!v_d[k]) d_d[k] = '0;
      end
    end

    if (in_fire && !out_fire)      occ_d = occ_q + OW'(1);
    else if (!in_fire && out_fire) occ_d = occ_q - OW'(1);

    if (flush) begin
      v_d   = '0;
      d_d   = '0;
      occ_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

  // Outputs come straight from the last-stage registers.
  always_comb begin
    out_valid  = v_q[DEPTH-1];
    out_shares = d_q[DEPTH-1];
    occupancy  = occ_q;
  end

endmodule

// File: tb/tb_share_register_pipeline.sv
// Self-checking bench: two instances (idle zeroing on/off) driven by the same
// stimulus, compared each cycle against a queue-based word/position model,
// plus directed scenarios with hand-computed expectations.
module tb_share_register_pipeline;

  localparam int unsigned SHARES = 3;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned DW     = SHARES * WIDTH;
  localparam int unsigned OW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_shares = '0;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_shares1, out_shares0;
  logic [OW-1:0] occupancy1, occupancy0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  share_register_pipeline #(.SHARES(SHARES), .WIDTH(WIDTH), .DEPTH(DEPTH),
                            .CLEAR_ON_IDLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready1), .in_shares(in_shares), .out_valid(out_valid1),
    .out_ready(out_ready), .out_shares(out_shares1), .occupancy(occupancy1));

  share_register_pipeline #(.SHARES(SHARES), .WIDTH(WIDTH), .DEPTH(DEPTH),
                            .CLEAR_ON_IDLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready0), .in_shares(in_shares), .out_valid(out_valid0),
    .out_ready(out_ready), .out_shares(out_shares0), .occupancy(occupancy0));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: words in flight, oldest first, each with its stage position.
  logic [DW-1:0] q_w[$];
  int            q_p[$];
  logic [DW-1:0] last0;   // last word that reached the output stage (hold mode)

  always @(posedge clk or negedge rst_n) begin
    int lim;
    int np;
    logic fire;
    if (!rst_n) begin
      q_w.delete(); q_p.delete(); last0 = '0;
    end else if (flush) begin
      q_w.delete(); q_p.delete(); last0 = '0;
    end else begin
      fire = in_valid && (q_w.size() < DEPTH || out_ready);
      if (out_ready && q_p.size() > 0 && q_p[0] == int'(DEPTH) - 1) begin
        void'(q_w.pop_front());
        void'(q_p.pop_front());
      end
      lim = int'(DEPTH);
      for (int i = 0; i < q_p.size(); i++) begin
        np = (q_p[i] + 1 < lim) ? q_p[i] + 1 : q_p[i];
        q_p[i] = np;
        lim = np;
      end
      if (fire) begin
        q_w.push_back(in_shares);
        q_p.push_back(0);
      end
      if (q_p.size() > 0 && q_p[0] == int'(DEPTH) - 1) last0 = q_w[0];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic          e_ov, e_ir;
    logic [DW-1:0] e_os1, e_os0;
    e_ov  = (q_p.size() > 0 && q_p[0] == int'(DEPTH) - 1);
    e_os1 = e_ov ? q_w[0] : '0;
    e_os0 = e_ov ? q_w[0] : last0;
    e_ir  = !flush && (q_w.size() < DEPTH || out_ready);
    chk("in_ready",     32'(in_ready1),   32'(e_ir));
    chk("in_ready_h",   32'(in_ready0),   32'(e_ir));
    chk("out_valid",    32'(out_valid1),  32'(e_ov));
    chk("out_valid_h",  32'(out_valid0),  32'(e_ov));
    chk("out_shares",   32'(out_shares1), 32'(e_os1));
    chk("out_shares_h", 32'(out_shares0), 32'(e_os0));
    chk("occupancy",    32'(occupancy1),  32'(q_w.size()));
    chk("occupancy_h",  32'(occupancy0),  32'(q_w.size()));
  end

  task automatic drive(input logic iv, input logic [DW-1:0] w, input logic ordy, input logic fl);
    in_valid = iv; in_shares = w; out_ready = ordy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_out_shares", 32'(out_shares1), 32'd0);
    chk("rst_occupancy", 32'(occupancy1), 32'd0);
    chk("rst_in_ready", 32'(in_ready1), 32'd1);

    // Latency / streaming
    drive(1'b1, 12'h321, 1'b1, 1'b0); tick();
    drive(1'b1, 12'h654, 1'b1, 1'b0); tick();
    chk("lat_not_yet", 32'(out_valid1), 32'd0);
    drive(1'b1, 12'h987, 1'b1, 1'b0); tick();
    chk("lat_w0_valid", 32'(out_valid1), 32'd1);
    chk("lat_w0", 32'(out_shares1), 32'h321);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("lat_w1", 32'(out_shares1), 32'h654);
    tick();
    chk("lat_w2", 32'(out_shares1), 32'h987);
    tick();
    chk("lat_empty_valid", 32'(out_valid1), 32'd0);
    chk("lat_empty_shares", 32'(out_shares1), 32'd0);

    // Backpressure
    drive(1'b1, 12'hA01, 1'b0, 1'b0); tick();
    drive(1'b1, 12'hA02, 1'b0, 1'b0); tick();
    drive(1'b1, 12'hA03, 1'b0, 1'b0); tick();
    drive(1'b1, 12'hA04, 1'b0, 1'b0); #1;
    chk("bp_full_in_ready", 32'(in_ready1), 32'd0);
    chk("bp_full_occ", 32'(occupancy1), 32'd3);
    tick();
    chk("bp_stall_occ", 32'(occupancy1), 32'd3);
    chk("bp_stall_head", 32'(out_shares1), 32'hA01);
    drive(1'b1, 12'hA04, 1'b1, 1'b0); #1;
    chk("bp_drain_fill_ready", 32'(in_ready1), 32'd1);
    tick();
    chk("bp_swap_occ", 32'(occupancy1), 32'd3);
    chk("bp_swap_head", 32'(out_shares1), 32'hA02);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    tick();
    chk("bp_last", 32'(out_shares1), 32'hA04);
    tick();
    chk("bp_empty", 32'(occupancy1), 32'd0);

    // Bubble collapse
    drive(1'b1, 12'h111, 1'b0, 1'b0); tick();
    idle(1);
    drive(1'b1, 12'h222, 1'b0, 1'b0); tick();
    idle(2);
    chk("bub_occ", 32'(occupancy1), 32'd2);
    chk("bub_head", 32'(out_shares1), 32'h111);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("bub_second", 32'(out_shares1), 32'h222);
    chk("bub_second_valid", 32'(out_valid1), 32'd1);
    tick();
    chk("bub_done", 32'(out_valid1), 32'd0);

    // Flush with an offered word
    drive(1'b1, 12'hB01, 1'b0, 1'b0); tick();
    drive(1'b1, 12'hB02, 1'b0, 1'b0); tick();
    drive(1'b1, 12'hB03, 1'b0, 1'b0); tick();
    drive(1'b1, 12'hFFF, 1'b1, 1'b1); #1;
    chk("fl_in_ready", 32'(in_ready1), 32'd0);
    tick();
    chk("fl_occ", 32'(occupancy1), 32'd0);
    chk("fl_valid", 32'(out_valid1), 32'd0);
    chk("fl_shares", 32'(out_shares1), 32'd0);
    chk("fl_shares_h", 32'(out_shares0), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_fff", 32'(out_valid1), 32'd0);
    end

    // Hold-mode instance keeps the last word visible after it leaves
    drive(1'b1, 12'h5A3, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0); tick(); tick(); tick();
    chk("hold_valid", 32'(out_valid0), 32'd0);
    chk("hold_shares", 32'(out_shares0), 32'h5A3);
    chk("clear_shares", 32'(out_shares1), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    chk("hold_flushed", 32'(out_shares0), 32'd0);

    // Asynchronous reset mid-stream
    drive(1'b1, 12'hC01, 1'b0, 1'b0); tick();
    drive(1'b1, 12'hC02, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("ar_pre_occ", 32'(occupancy1), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_occ", 32'(occupancy1), 32'd0);
    chk("ar_valid", 32'(out_valid1), 32'd0);
    chk("ar_shares", 32'(out_shares1), 32'd0);
    #3 rst_n = 1'b1;
    #1;
    chk("ar_in_ready", 32'(in_ready1), 32'd1);
    tick();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 9) < 7), DW'($urandom), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 99) < 3));
      tick();
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
